// File: rtl/carregador_cromossomo.sv
// Serial chromosome loader: assembles a byte stream into a shadow word, verifies a trailing XOR checksum, commits on match.
// Latency: checksum byte accepted at edge N -> cromossomo/load_done (or err_checksum) update at edge N+1.
// Backpressure: in_ready is high only in LOAD/CHECK; bytes offered in IDLE are ignored, gaps on in_valid are legal.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   load_start        one-cycle pulse; starts a load, or aborts and restarts one in progress
//   in_data/in_valid  stream byte and its qualifier; in_ready says the loader will take it
//   cromossomo        committed chromosome, changes only at a good commit or reset
//   crom_valid        cromossomo holds at least one good load
//   load_done         one-cycle pulse on a good commit
//   err_checksum      one-cycle pulse on a checksum mismatch (nothing committed)
//   busy              load in progress (LOAD or CHECK)
module carregador_cromossomo #(
   parameter int CHROM_BITS = 468,
   parameter int BYTE_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_start,
   input  logic [BYTE_W-1:0]     in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [CHROM_BITS-1:0] cromossomo,
   output logic                  crom_valid,
   output logic                  load_done,
   output logic                  err_checksum,
   output logic                  busy
);

   localparam int NUM_BYTES = (CHROM_BITS + BYTE_W - 1) / BYTE_W;
   localparam int SHADOW_W  = NUM_BYTES * BYTE_W;
   localparam int CNT_W     = $clog2(NUM_BYTES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_CHECK = 2'd2
   } state_t;

   state_t                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [BYTE_W-1:0]       chk_q;
   logic [SHADOW_W-1:0]     shadow_q;
   logic                    commit_q;   // checksum matched last edge; copy shadow this edge
   logic                    fail_q;     // checksum mismatched last edge; flag error this edge
   logic [CHROM_BITS-1:0]   crom_q;
   logic                    crom_vld_q;
   logic                    done_q;
   logic                    err_q;

   assign in_ready     = (state_q != S_IDLE);
   assign busy         = (state_q != S_IDLE);
   assign cromossomo   = crom_q;
   assign crom_valid   = crom_vld_q;
   assign load_done    = done_q;
   assign err_checksum = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         chk_q      <= '0;
         shadow_q   <= '0;
         commit_q   <= 1'b0;
         fail_q     <= 1'b0;
         crom_q     <= '0;
         crom_vld_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         commit_q <= 1'b0;
         fail_q   <= 1'b0;

         // Commit reads the shadow before any same-edge restart clears it,
         // so a load_start coinciding with the commit still commits the old frame.
         if (commit_q) begin
            crom_q     <= shadow_q[CHROM_BITS-1:0];
            crom_vld_q <= 1'b1;
            done_q     <= 1'b1;
         end
         if (fail_q) begin
            err_q <= 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               if (load_start) begin
                  state_q  <= S_LOAD;
                  cnt_q    <= '0;
                  chk_q    <= '0;
                  shadow_q <= '0;
               end
            end

            S_LOAD, S_CHECK: begin
               if (load_start) begin
                  // Abort: restart from scratch, any byte on this edge is dropped.
                  state_q  <= S_LOAD;
                  cnt_q    <= '0;
                  chk_q    <= '0;
                  shadow_q <= '0;
               end else if (in_valid) begin
                  if (state_q == S_LOAD) begin
                     shadow_q[int'(cnt_q)*BYTE_W +: BYTE_W] <= in_data;
                     chk_q <= chk_q ^ in_data;
                     if (cnt_q == CNT_LAST) begin
                        state_q <= S_CHECK;
                     end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                     end
                  end else begin
                     if (in_data == chk_q) begin
                        commit_q <= 1'b1;
                     end else begin
                        fail_q <= 1'b1;
                     end
                     state_q <= S_IDLE;
                  end
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_carregador_cromossomo.sv
// Directed bench for carregador_cromossomo: good/bad checksum, gapped stream, abort, reset mid-load, 0xFF tail byte.
// Inputs are driven 1 ns after the rising edge; outputs are sampled at the same point.
// All expectations are constants or built from the frame table held by the bench.
module tb_carregador_cromossomo;

   localparam int CB = 468;
   localparam int NB = 59;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_start;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic [CB-1:0] cromossomo;
   logic          crom_valid;
   logic          load_done;
   logic          err_checksum;
   logic          busy;

   int n_checks  = 0;
   int n_errors  = 0;
   int not_ready = 0;
   int busy_drop = 0;

   logic [7:0]    frame [NB];
   logic [7:0]    csum;
   logic [CB-1:0] saved_crom;

   always #5 clk = ~clk;

   carregador_cromossomo #(.CHROM_BITS(CB), .BYTE_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .load_start   (load_start),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .cromossomo   (cromossomo),
      .crom_valid   (crom_valid),
      .load_done    (load_done),
      .err_checksum (err_checksum),
      .busy         (busy)
   );

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected chromosome: bytes 0..57 whole, only the low nibble of byte 58.
   function automatic logic [CB-1:0] exp_crom();
      logic [CB-1:0] e;
      e = '0;
      for (int k = 0; k < NB - 1; k++) e[8*k +: 8] = frame[k];
      e[CB-1 -: 4] = frame[NB-1][3:0];
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic send_bytes(input int first, input int last, input int gap);
      for (int k = first; k <= last; k++) begin
         if (!in_ready) not_ready++;
         in_valid = 1'b1;
         in_data  = frame[k];
         tick();
         in_valid = 1'b0;
         for (int g = 0; g < gap; g++) begin
            tick();
            if (!busy) busy_drop++;
         end
      end
   endtask

   task automatic finish_frame(input logic [7:0] cs, input bit good, input string tag);
      if (!in_ready) not_ready++;
      in_valid = 1'b1;
      in_data  = cs;
      tick();
      in_valid = 1'b0;
      check({tag, "_busy_after_csum"}, busy, 1'b0);
      check({tag, "_done_not_yet"}, load_done, 1'b0);
      tick();
      check({tag, "_load_done"}, load_done, good);
      check({tag, "_err_checksum"}, err_checksum, !good);
      tick();
      check({tag, "_pulses_end"}, {load_done, err_checksum}, 2'b00);
   endtask

   task automatic fill_counting();
      for (int k = 0; k < NB; k++) frame[k] = 8'(k + 1);
   endtask

   initial begin
      rst        = 1'b1;
      load_start = 1'b0;
      in_data    = '0;
      in_valid   = 1'b0;
      tick();
      tick();
      check("rst_crom",       cromossomo,   '0);
      check("rst_outputs",    {in_ready, crom_valid, load_done, err_checksum, busy}, 5'b0);
      rst = 1'b0;
      tick();

      // Bytes offered in IDLE must be ignored.
      in_valid = 1'b1;
      in_data  = 8'h77;
      tick();
      in_valid = 1'b0;
      check("idle_ready", in_ready, 1'b0);
      check("idle_busy",  busy,     1'b0);

      // Bad checksum straight after reset: XOR of 0x01..0x3B is 0x00, send 0x01.
      fill_counting();
      pulse_start();
      check("load_ready", in_ready, 1'b1);
      send_bytes(0, NB - 1, 0);
      finish_frame(8'h01, 1'b0, "bad_csum");
      check("bad_crom_kept",  cromossomo, '0);
      check("bad_valid_kept", crom_valid, 1'b0);

      // Good frame 0x01..0x3B, checksum 0x00.
      pulse_start();
      send_bytes(0, NB - 1, 0);
      finish_frame(8'h00, 1'b1, "good");
      check("good_b0",     cromossomo[7:0],    8'h01);
      check("good_b1",     cromossomo[15:8],   8'h02);
      check("good_top",    cromossomo[467:464], 4'hB);
      check("good_valid",  crom_valid,         1'b1);
      check("good_full",   cromossomo,         exp_crom());

      // Same frame with 3 idle cycles between bytes.
      busy_drop = 0;
      pulse_start();
      send_bytes(0, NB - 1, 3);
      finish_frame(8'h00, 1'b1, "gapped");
      check("gapped_full",      cromossomo, exp_crom());
      check("gapped_busy_drop", busy_drop,  0);

      // Abort after 20 bytes; the byte offered with load_start must be dropped.
      saved_crom = cromossomo;
      for (int k = 0; k < NB; k++) frame[k] = 8'hAA;
      pulse_start();
      send_bytes(0, 19, 0);
      load_start = 1'b1;
      in_valid   = 1'b1;
      in_data    = 8'h55;
      tick();
      load_start = 1'b0;
      in_valid   = 1'b0;
      check("abort_busy", busy,       1'b1);
      check("abort_crom", cromossomo, saved_crom);
      csum = 8'h00;
      for (int k = 0; k < NB; k++) begin
         frame[k] = 8'(k * 7 + 3);
         csum     = csum ^ frame[k];
      end
      send_bytes(0, NB - 1, 0);
      finish_frame(csum, 1'b1, "abort");
      check("abort_second_frame", cromossomo, exp_crom());

      // Last data byte 0xFF: XOR of 0x01..0x3A is 0x3B, ^0xFF gives 0xC4.
      fill_counting();
      frame[NB-1] = 8'hFF;
      pulse_start();
      send_bytes(0, NB - 1, 0);
      finish_frame(8'hC4, 1'b1, "ff_tail");
      check("ff_top",      cromossomo[467:464], 4'hF);
      check("ff_byte57",   cromossomo[463:456], 8'h3A);
      check("ff_full",     cromossomo,          exp_crom());

      // Reset after 30 bytes, then a full good load.
      pulse_start();
      send_bytes(0, 29, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_crom",    cromossomo, '0);
      check("mid_rst_outputs", {in_ready, crom_valid, load_done, err_checksum, busy}, 5'b0);
      fill_counting();
      pulse_start();
      send_bytes(0, NB - 1, 0);
      finish_frame(8'h00, 1'b1, "after_rst");
      check("after_rst_full",  cromossomo, exp_crom());
      check("after_rst_valid", crom_valid, 1'b1);

      check("never_not_ready", not_ready, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
